axi_rd_arbiter: RTL

- Shares the single AXI read port (AR/R channels) between two requesters: m0 = instruction fetch, m1 = vector load unit.
- Accepts one request at a time, drives the AR phase from registered copies of the request, then routes R beats back to the granted requester.
- Sits between the fetch/load units and the memory interconnect.
- Only one transaction is outstanding at a time.

---
 rtl/axi_rd_arbiter.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI read port (AR/R) between m0 (instruction fetch) and m1 (vector load).
// Latency: a request seen in IDLE in cycle N puts ARVALID high in N+1; R beats are routed combinationally.
// Backpressure: ARVALID is held until ARREADY; RREADY follows the granted requester's rready.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   m0_* / m1_*           requester AR inputs, one-cycle arready accept pulse, routed R beats
//   AR* / R*              downstream AXI read address and data channels
//   rid_err               sticky flag: a beat arrived with RID != ARID of the active transaction
//
// Build option: define AXI_RD_ARB_RR_EN for round-robin arbitration between
// simultaneous requests; left undefined, m0 has fixed priority and no
// last-grant history is kept.
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  // requester 0 (instruction fetch)
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [7:0]        m0_arlen,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  // requester 1 (vector load)
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [7:0]        m1_arlen,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  // downstream AXI read port
  output logic [ADDR_W-1:0] ARADDR,
  output logic [7:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [2:0]        ARPROT,
  output logic [ID_W-1:0]   ARID,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic [ID_W-1:0]   RID,
  input  logic              RVALID,
  output logic              RREADY,
  output logic              rid_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q;
  logic                grant_q;
  logic [ADDR_W-1:0]   araddr_q;
  logic [7:0]          arlen_q;
  logic [ID_W-1:0]     arid_q;
  logic [2:0]          arprot_q;
  logic                rid_err_q;

  logic                any_req;
  logic                accept;
  logic                win;
  logic                ar_hs;
  logic                r_hs;
  logic                last_beat;

  assign any_req = m0_arvalid | m1_arvalid;
  assign accept  = (state_q == S_IDLE) && any_req;

  // Winner index; only meaningful while accept is high.
`ifdef AXI_RD_ARB_RR_EN
  logic last_grant_q;

  always_comb begin
    win = m1_arvalid;
    if (m0_arvalid && m1_arvalid) begin
      // alternate: whoever was not served last goes now
      win = ~last_grant_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;  // so m0 wins the first contested round
    end else if (r_hs && last_beat) begin
      last_grant_q <= grant_q;
    end
  end
`else
  always_comb begin
    win = ~m0_arvalid;  // m0 always has priority
  end
`endif

  // Accept pulse goes to the winner only, for the single IDLE cycle.
  always_comb begin
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    if (accept) begin
      m0_arready = ~win;
      m1_arready = win;
    end
  end

  // Downstream AR channel straight from registers.
  assign ARVALID = (state_q == S_AR);
  assign ARADDR  = araddr_q;
  assign ARLEN   = arlen_q;
  assign ARID    = arid_q;
  assign ARPROT  = arprot_q;
  assign ARSIZE  = 3'b010;
  assign ar_hs   = ARVALID && ARREADY;

  // R channel routing; nothing leaks through outside the R state.
  always_comb begin
    RREADY    = 1'b0;
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    m0_rresp  = 2'b00;
    m1_rresp  = 2'b00;
    if (state_q == S_R) begin
      if (grant_q) begin
        RREADY    = m1_rready;
        m1_rvalid = RVALID;
        m1_rdata  = RDATA;
        m1_rresp  = RRESP;
      end else begin
        RREADY    = m0_rready;
        m0_rvalid = RVALID;
        m0_rdata  = RDATA;
        m0_rresp  = RRESP;
      end
    end
  end

  assign r_hs      = (state_q == S_R) && RVALID && RREADY;
  assign last_beat = (cnt_q == 8'd0);
  assign rid_err   = rid_err_q;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) state_d = S_AR;
      end
      S_AR: begin
        if (ar_hs) state_d = S_R;
      end
      S_R: begin
        if (r_hs && last_beat) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request capture, beat counting and ID checking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 8'd0;
      grant_q   <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= 8'd0;
      arid_q    <= '0;
      arprot_q  <= 3'b000;
      rid_err_q <= 1'b0;
    end else begin
      if (accept) begin
        grant_q  <= win;
        araddr_q <= win ? m1_araddr : m0_araddr;
        arlen_q  <= win ? m1_arlen  : m0_arlen;
        arid_q   <= ID_W'(win);
        arprot_q <= win ? 3'b000 : 3'b100;  // m0 traffic is instruction fetch
      end
      if (ar_hs) begin
        cnt_q <= arlen_q;
      end
      if (r_hs) begin
        if (!last_beat) cnt_q <= cnt_q - 8'd1;
        // mismatched beat is still delivered and counted, only flagged
        if (RID != arid_q) rid_err_q <= 1'b1;
      end
    end
  end

endmodule
